sram_bus_arbiter: RTL
=====================

Name: sram_bus_arbiter

Overview:
- Shares the single sram-like data bus between two requesters: instruction fetch (inst port) and the memory stage (data port).
- Serialises transactions with at most one outstanding at a time.
- Applies the kseg0/kseg1 address mapping (0x8xxxxxxx–0xBxxxxxxx → top 3 bits cleared).
- Routes each response back to its owner and discards fetch responses cancelled by an exception flush.
- Sits between the fetch/memory stages and the top-level sram-like interface.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while an inst request waits before inst is forced.
CNT_W, 3, width of the streak counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
flush  in  1  exception/eret pipeline flush; cancels inst response delivery
inst_req  in  1  fetch request; held until inst_addr_ok
inst_addr  in  32  fetch virtual address (word read, size 2)
inst_addr_ok  out  1  fetch request accepted by bus
inst_data_ok  out  1  fetch data valid
inst_rdata  out  32  fetch data
data_req  in  1  load/store request; held until data_addr_ok
data_wr  in  1  1 = store
data_size  in  2  0 byte, 1 half, 2 word
data_wstrb  in  4  byte enables for store
data_addr  in  32  virtual address
data_wdata  in  32  store data, already byte-replicated
data_addr_ok  out  1  data request accepted by bus
data_data_ok  out  1  load data valid / store complete
data_rdata  out  32  load data, raw word
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_wstrb  out  4  bus byte enables
bus_addr  out  32  mapped physical address
bus_wdata  out  32  bus write data
bus_addr_ok  in  1  bus accepted request
bus_data_ok  in  1  bus response
bus_rdata  in  32  bus read data

Behaviour:
- Reset: state IDLE; owner=DATA; discard=0; streak=0; all bus_* outputs 0; all requester outputs 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is present, grant, latch the winner's fields into bus_* registers and go to REQ; bus_req=1 from the next cycle.
  - Grant priority: data wins, except inst wins when inst_req=1 and streak==STARVE_LIMIT.
  - Inst grant: bus_wr=0, bus_size=2, bus_wstrb=0, bus_wdata=0.
  - Store grant: bus_wstrb is forced to 0 when data_wr=0.
- Address mapping: if addr[31:28] is in 8..B then bus_addr={3'b0,addr[28:0]}, else addr unchanged.
- Streak counter:
  - Data grant with inst_req=1 → streak+1, saturating at STARVE_LIMIT.
  - Inst grant → 0.
  - Data grant with inst_req=0 → 0.
- REQ:
  - bus_req=1; all bus_* fields stable.
  - On bus_addr_ok: the owner's *_addr_ok=1 in that same cycle (combinational), bus_req drops next cycle, go to RESP.
- RESP:
  - bus_req=0. bus_data_ok is not expected in the same cycle as bus_addr_ok.
  - On bus_data_ok: owner's *_data_ok=1 and *_rdata=bus_rdata in that same cycle, go to IDLE. Exception: owner=INST and discard=1 → inst_data_ok stays 0.
  - discard clears on leaving RESP.
- Flush:
  - flush=1 while owner=INST in REQ or RESP sets discard.
  - The bus request is never withdrawn mid-handshake, so REQ keeps bus_req=1 until addr_ok.
  - inst_addr_ok is still reported if flush coincides with bus_addr_ok.
  - Flush has no effect on data transactions or in IDLE.
- Outputs when not owner: *_addr_ok=0, *_data_ok=0; rdata outputs may carry bus_rdata.
- Minimum transaction: 3 cycles (IDLE grant, REQ with immediate addr_ok, RESP with data_ok); back-to-back transactions pass through one IDLE cycle.
- Simultaneous inst_req and data_req: the loser's req remains high and is granted in a later IDLE.
- Reset mid-transaction: immediate return to IDLE with bus_req=0. The slave side is also reset by the same reset, so no response is awaited.

Test Plan:
- Single load: data_req, addr 0x8000_1004, size 2, addr_ok after 1 wait cycle, data_ok with rdata 0xDEADBEEF → bus_addr 0x0000_1004, bus_wr 0, data_addr_ok one pulse, data_data_ok with 0xDEADBEEF, inst outputs 0.
- Byte store: data_wr 1, size 0, wstrb 4'b0100, addr 0xBFC0_0002, wdata 0x5A5A5A5A → bus_addr 0x1FC0_0002, bus_wstrb 4'b0100, bus_wr 1; data_data_ok on response; kuseg addr 0x0040_0000 passes unmapped.
- Simultaneous inst_req and data_req held continuously with zero-latency slave → grant order DATA×4, INST, DATA×4, INST (STARVE_LIMIT=4).
- flush while inst owner in RESP, then bus_data_ok → inst_data_ok stays 0; next data request is granted normally.
- flush in REQ coinciding with bus_addr_ok → inst_addr_ok=1, response later suppressed.
- reset asserted in RESP → next cycle all outputs 0, state IDLE, streak 0; a new data_req proceeds normally.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: serialises fetch and memory-stage requests onto one sram-like bus,
// applying kseg0/kseg1 mapping and routing each response back to its owner.
module sram_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    state_t           state_q, state_d;
    logic             owner_inst_q, owner_inst_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic             bus_wr_q, bus_wr_d;
    logic [1:0]       bus_size_q, bus_size_d;
    logic [3:0]       bus_wstrb_q, bus_wstrb_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic             grant_inst;
    logic [31:0]      grant_vaddr;
    always_comb begin
        grant_inst   = inst_req && (!data_req || streak_q == LIMIT);
        grant_vaddr  = grant_inst ? inst_addr : data_addr;
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        discard_d    = discard_q;
        streak_d     = streak_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if (state_q == IDLE && (inst_req || data_req)) begin
            state_d      = REQ;
            owner_inst_d = grant_inst;
            discard_d    = 1'b0;
            streak_d     = (grant_inst || !inst_req) ? '0 :
                           (streak_q == LIMIT) ? streak_q : streak_q + CNT_W'(1);
            bus_wr_d     = !grant_inst && data_wr;
            bus_size_d   = grant_inst ? 2'd2 : data_size;
            bus_wstrb_d  = (!grant_inst && data_wr) ? data_wstrb : 4'h0;
            // kseg0/kseg1 (0x8..0xB) fold onto physical by clearing the top three bits
            bus_addr_d   = (grant_vaddr[31:30] == 2'b10) ? {3'b000, grant_vaddr[28:0]} : grant_vaddr;
            bus_wdata_d  = grant_inst ? 32'h0 : data_wdata;
        end
        if (state_q == REQ && bus_addr_ok)
            state_d = RESP;
        if (state_q != IDLE && owner_inst_q && flush)
            discard_d = 1'b1;
        if (state_q == RESP && bus_data_ok) begin
            state_d   = IDLE;
            discard_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_inst_q <= 1'b0;
            discard_q    <= 1'b0;
            streak_q     <= '0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_wstrb_q  <= 4'h0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            discard_q    <= discard_d;
            streak_q     <= streak_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end
    assign bus_req      = state_q == REQ;
    assign bus_wr       = bus_wr_q;
    assign bus_size     = bus_size_q;
    assign bus_wstrb    = bus_wstrb_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign inst_addr_ok = state_q == REQ && bus_addr_ok && owner_inst_q;
    assign data_addr_ok = state_q == REQ && bus_addr_ok && !owner_inst_q;
    assign inst_data_ok = state_q == RESP && bus_data_ok && owner_inst_q && !discard_q;
    assign data_data_ok = state_q == RESP && bus_data_ok && !owner_inst_q;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'h0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'h0;
endmodule
